edge_pattern_gen: RTL and testbench

Transmit-side counterpart to the team's positive/negative edge detection logic: accepts a queue of edge commands (rise or fall, plus a hold time) and drives a single-bit level output that produces exactly those edges, spaced so a downstream edge detector sees each one cleanly. It sits in front of the edge detector in loopback benches and drives strobe/handshake lines that other blocks edge-detect. The block contains a small command FIFO, a two-state sequencer and a hold counter.

---
 rtl/edge_pattern_gen_if.sv | 25 ++
 rtl/edge_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_edge_pattern_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/edge_pattern_gen_if.sv
// Command and level bundle for edge_pattern_gen: the command handshake plus
// the generated level, its edge pulses and the status flags.
interface edge_pattern_gen_if #(
  parameter int HW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [HW-1:0] cmd_hold;
  logic          sig_out;
  logic          edge_pos;
  logic          edge_neg;
  logic          err_redundant;
  logic          busy;

  modport master (
    output cmd_valid, cmd_dir, cmd_hold,
    input  cmd_ready, sig_out, edge_pos, edge_neg, err_redundant, busy
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_hold,
    output cmd_ready, sig_out, edge_pos, edge_neg, err_redundant, busy
  );
endinterface

// File: rtl/edge_pattern_gen.sv
// Edge pattern generator: queues rise/fall commands with hold times and
// drives a single level that produces exactly those edges, each new level
// held stable for max(hold, MIN_HOLD) cycles before the next edge.
module edge_pattern_gen #(
  parameter int   DEPTH      = 4,
  parameter int   HW         = 8,
  parameter int   MIN_HOLD   = 2,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  edge_pattern_gen_if.slave   bus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [HW-1:0] MIN_H    = HW'(MIN_HOLD);
  localparam logic [HW-1:0] ONE_H    = HW'(1);
  localparam logic [AW-1:0] ONE_P    = AW'(1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Effective hold: short or zero requests are stretched to MIN_HOLD so the
  // downstream detector always sees a clean level between edges.
  function automatic logic [HW-1:0] clamp_hold(input logic [HW-1:0] h);
    return (h < MIN_H) ? MIN_H : h;
  endfunction

  // Command FIFO: entry = {dir, hold}
  logic [HW:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          wr_en;

  // Sequencer
  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] cnt;
  logic [HW-1:0] cnt_nxt;
  logic          sig;
  logic          sig_nxt;
  logic          pos_r, neg_r, err_r;
  logic          pos_nxt, neg_nxt, err_nxt;
  logic          pop;
  logic          toggle;
  logic          head_dir;
  logic [HW-1:0] head_hold;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  // Ready looks only at current occupancy: a pop this cycle does not free a
  // slot for a same-cycle write.
  assign bus.cmd_ready = !fifo_full && !rst;
  assign wr_en         = bus.cmd_valid && bus.cmd_ready;

  assign {head_dir, head_hold} = fifo_mem[rd_ptr];
  // The head is consumed whenever the sequencer is free to act on it.
  assign pop    = !fifo_empty && ((state == IDLE) || (cnt == '0));
  assign toggle = (head_dir != sig);

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= {bus.cmd_dir, bus.cmd_hold};
  end

  // FIFO pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE_P;
      if (pop)   rd_ptr <= rd_ptr + ONE_P;
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + ONE_C;
        2'b01:   fifo_cnt <= fifo_cnt - ONE_C;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // State register plus registered level, counter and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sig   <= INIT_LEVEL;
      pos_r <= 1'b0;
      neg_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sig   <= sig_nxt;
      pos_r <= pos_nxt;
      neg_r <= neg_nxt;
      err_r <= err_nxt;
    end
  end

  // Next state: a toggling pop enters or stays in HOLD; an expired hold with
  // nothing to toggle returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop && toggle) state_nxt = HOLD;
      HOLD:    if ((cnt == '0) && !(pop && toggle)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: apply or drop the popped command, otherwise run the hold down.
  always_comb begin
    cnt_nxt = cnt;
    sig_nxt = sig;
    pos_nxt = 1'b0;
    neg_nxt = 1'b0;
    err_nxt = 1'b0;
    if (pop) begin
      if (toggle) begin
        sig_nxt = head_dir;
        pos_nxt = head_dir;
        neg_nxt = !head_dir;
        cnt_nxt = clamp_hold(head_hold) - ONE_H;
      end else begin
        err_nxt = 1'b1;
        cnt_nxt = '0;
      end
    end else if ((state == HOLD) && (cnt != '0)) begin
      cnt_nxt = cnt - ONE_H;
    end
  end

  assign bus.sig_out       = sig;
  assign bus.edge_pos      = pos_r;
  assign bus.edge_neg      = neg_r;
  assign bus.err_redundant = err_r;
  assign bus.busy          = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Testbench for edge_pattern_gen: hand-computed cycle table, directed
// full-FIFO and mid-hold reset sequences, and randomized traffic compared
// against a time-based behavioural model.
module tb_edge_pattern_gen;

  localparam int DEPTH    = 4;
  localparam int HW       = 8;
  localparam int MIN_HOLD = 2;
  localparam bit INIT     = 1'b0;

  logic clk;
  logic rst;

  edge_pattern_gen_if #(.HW(HW)) bus ();

  edge_pattern_gen #(
    .DEPTH(DEPTH), .HW(HW), .MIN_HOLD(MIN_HOLD), .INIT_LEVEL(INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: commands wait in a queue; a pop may happen once the
  // current edge index reaches next_pop; a toggle holds for H edges.
  typedef struct packed { bit dir; int hold; } cmd_t;
  cmd_t mq[$];
  int   cyc        = 0;
  int   next_pop   = 0;
  int   hold_until = 0;
  bit   m_level    = INIT;
  bit   m_pos, m_neg, m_err, m_busy, m_acc;
  bit   exp_ready, pre_ready;

  task automatic model_edge(input bit r, input bit v, input bit d, input logic [7:0] h);
    cmd_t c;
    int   hh;
    m_pos = 0; m_neg = 0; m_err = 0; m_acc = 0;
    if (r) begin
      mq.delete();
      m_level    = INIT;
      next_pop   = cyc;
      hold_until = cyc;
    end else begin
      m_acc = v && (mq.size() < DEPTH);
      if ((mq.size() > 0) && (cyc >= next_pop)) begin
        c = mq.pop_front();
        if (c.dir != m_level) begin
          m_level = c.dir;
          if (c.dir) m_pos = 1; else m_neg = 1;
          hh = (c.hold < MIN_HOLD) ? MIN_HOLD : c.hold;
          next_pop   = cyc + hh;
          hold_until = cyc + hh;
        end else begin
          m_err    = 1;
          next_pop = cyc + 1;
        end
      end
      if (m_acc) begin
        c.dir  = d;
        c.hold = int'(h);
        mq.push_back(c);
      end
    end
    m_busy = (mq.size() > 0) || (cyc < hold_until);
    cyc++;
  endtask

  // One clock: drive at the falling edge, sample ready before the rising
  // edge, advance the model at the rising edge, leave time just after it.
  task automatic apply(input bit r, input bit v, input bit d, input logic [7:0] h);
    @(negedge clk);
    rst           = r;
    bus.cmd_valid = v;
    bus.cmd_dir   = d;
    bus.cmd_hold  = h;
    #1;
    pre_ready = bus.cmd_ready;
    exp_ready = !r && (mq.size() < DEPTH);
    @(posedge clk);
    model_edge(r, v, d, h);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ready"}, pre_ready, exp_ready);
    check({tag, "_sig"},   bus.sig_out, m_level);
    check({tag, "_pos"},   bus.edge_pos, m_pos);
    check({tag, "_neg"},   bus.edge_neg, m_neg);
    check({tag, "_err"},   bus.err_redundant, m_err);
    check({tag, "_busy"},  bus.busy, m_busy);
  endtask

  typedef struct packed {
    bit rst, vld, dir;
    logic [7:0] hold;
    bit ready, sig, pos, neg, err, busy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input bit d, input int h,
                     input bit rdy, input bit s, input bit p, input bit n,
                     input bit e, input bit b);
    vec_t x;
    x.rst = r; x.vld = v; x.dir = d; x.hold = 8'(h);
    x.ready = rdy; x.sig = s; x.pos = p; x.neg = n; x.err = e; x.busy = b;
    tbl.push_back(x);
  endtask

  int  n_edges, n_errs, n_acc, n_pulses, rate;
  bit  saw_full, drained;
  bit  r_r, r_d;
  logic [7:0] r_h;

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_hold  = '0;

    // ---------------- cycle table ----------------
    //   rst v d hold | ready sig pos neg err busy
    add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // single rise, hold 5
    add(0, 1, 1, 5,   1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,   1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
    // back-to-back fall/3, rise/0 (clamped to 2), fall/4
    add(0, 1, 0, 3,   1, 1, 0, 0, 0, 1);
    add(0, 1, 1, 0,   1, 0, 0, 1, 0, 1);
    add(0, 1, 0, 4,   1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,   1, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0,   1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0,   1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    // redundant fall/3 at level 0, then rise/3
    add(0, 1, 0, 3,   1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 3,   1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0,   1, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0,   1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0,   1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0,   1, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].vld, tbl[i].dir, tbl[i].hold);
      check($sformatf("vec%0d_ready", i), pre_ready,         tbl[i].ready);
      check($sformatf("vec%0d_sig", i),   bus.sig_out,       tbl[i].sig);
      check($sformatf("vec%0d_pos", i),   bus.edge_pos,      tbl[i].pos);
      check($sformatf("vec%0d_neg", i),   bus.edge_neg,      tbl[i].neg);
      check($sformatf("vec%0d_err", i),   bus.err_redundant, tbl[i].err);
      check($sformatf("vec%0d_busy", i),  bus.busy,          tbl[i].busy);
    end

    // ---------------- full FIFO, hold 10 ----------------
    apply(1, 0, 0, 0); check_model("full_rst");
    apply(1, 0, 0, 0); check_model("full_rst");
    n_edges = 0; n_errs = 0; n_acc = 0; saw_full = 0;
    for (int i = 0; i < 40; i++) begin
      apply(0, 1, 1'($urandom % 2), 8'd10);
      check_model("full_fill");
      if (!pre_ready) saw_full = 1;
      n_acc += int'(m_acc);
      if (bus.edge_pos || bus.edge_neg) n_edges++;
      if (bus.err_redundant) n_errs++;
    end
    drained = 0;
    for (int i = 0; i < 300 && !drained; i++) begin
      apply(0, 0, 0, 0);
      check_model("full_drain");
      if (bus.edge_pos || bus.edge_neg) n_edges++;
      if (bus.err_redundant) n_errs++;
      if (!bus.busy) drained = 1;
    end
    check("full_drain_idle", drained, 1);
    check("full_seen", saw_full, 1);
    check("full_conserve", n_edges, n_acc - n_errs);

    // ---------------- reset in the middle of a hold ----------------
    apply(1, 0, 0, 0); check_model("mid_rst");
    apply(0, 1, 1, 8'd10); check_model("mid_q");
    apply(0, 1, 0, 8'd3);  check_model("mid_q");
    check("mid_rise", bus.edge_pos, 1);
    apply(0, 1, 1, 8'd3);  check_model("mid_q");
    apply(0, 0, 0, 0);     check_model("mid_hold");
    apply(1, 0, 0, 0);     check_model("mid_reset");
    check("mid_reset_sig", bus.sig_out, INIT);
    check("mid_reset_busy", bus.busy, 0);
    n_pulses = 0;
    for (int i = 0; i < 25; i++) begin
      apply(0, 0, 0, 0);
      check_model("mid_after");
      if (bus.edge_pos || bus.edge_neg || bus.err_redundant) n_pulses++;
    end
    check("mid_no_pulses", n_pulses, 0);

    // ---------------- randomized traffic ----------------
    apply(1, 0, 0, 0); check_model("rnd_rst");
    rate = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) begin
        case ($urandom % 3)
          0:       rate = 20;
          1:       rate = 50;
          default: rate = 90;
        endcase
      end
      r_r = ($urandom % 200) == 0;
      r_d = 1'($urandom % 2);
      r_h = (($urandom % 4) == 0) ? 8'($urandom % 12) : 8'($urandom % 3);
      apply(r_r, ($urandom % 100) < rate, r_d, r_h);
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
